// File: rtl/cdc_hs_sender.sv
// Source end of a four-phase req/ack handshake: captures a word, holds it on the crossing
// bus, raises req and walks the ack through a resynchroniser before completing the cycle.
module cdc_hs_sender #(
   parameter int unsigned BUS_WIDTH      = 8,
   parameter int unsigned NUM_STAGES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] src_data,
   input  logic                 src_valid,
   output logic                 src_ready,
   output logic [BUS_WIDTH-1:0] tx_data,
   output logic                 req,
   input  logic                 ack,
   output logic                 done,
   output logic                 err
);

   localparam bit          TmoEn   = (TIMEOUT_CYCLES > 0);
   localparam int unsigned CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned CntLastI = TmoEn ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CntW-1:0] CntLast = CntW'(CntLastI);

   typedef enum logic [1:0] {
      StIdle,
      StWaitAckHi,
      StWaitAckLo
   } state_e;

   state_e                 state_q, state_d;
   logic [BUS_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                   req_q, req_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   abort_q, abort_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [NUM_STAGES-1:0]  sync_q;
   logic                   ack_s;
   logic                   tmo_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], ack};
      end
   end

   assign ack_s   = sync_q[NUM_STAGES-1];
   assign tmo_hit = TmoEn && (cnt_q == CntLast);

   // abort marks a transfer that timed out in the high phase so its low phase ends without done.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      req_d     = req_q;
      done_d    = 1'b0;
      err_d     = err_q;
      abort_d   = abort_q;
      cnt_d     = '0;
      unique case (state_q)
         StIdle: begin
            if (src_valid) begin
               tx_data_d = src_data;
               req_d     = 1'b1;
               abort_d   = 1'b0;
               state_d   = StWaitAckHi;
            end
         end
         StWaitAckHi: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = StWaitAckLo;
            end else if (tmo_hit) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               abort_d = 1'b1;
               state_d = StWaitAckLo;
            end else begin
               cnt_d = TmoEn ? cnt_q + CntW'(1) : '0;
            end
         end
         StWaitAckLo: begin
            if (!ack_s) begin
               done_d  = !abort_q;
               state_d = StIdle;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = TmoEn ? cnt_q + CntW'(1) : '0;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         tx_data_q <= '0;
         req_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         abort_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         req_q     <= req_d;
         done_q    <= done_d;
         err_q     <= err_d;
         abort_q   <= abort_d;
         cnt_q     <= cnt_d;
      end
   end

   assign src_ready = (state_q == StIdle);
   assign tx_data   = tx_data_q;
   assign req       = req_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
